fsm: RTL and testbench

Traffic-light controller for the SW 4th Avenue / SW Harrison Street intersection. It arbitrates between northbound 4th Avenue traffic and eastbound/westbound Harrison traffic using three vehicle sensors, and drives three 2-bit light outputs. Northbound is the arterial and is the rest phase: it stays green until a Harrison vehicle is detected. It is a standalone leaf block driven directly by sensor inputs.

---
 rtl/fsm.sv | 153 +++++++++++++++
 tb/tb_fsm.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fsm.sv
// Traffic-light controller, SW 4th Ave (northbound) / SW Harrison (east/west).
// Define FSM_SAFETY_ASSERT_EN to compile in the safety and dwell assertions.
module fsm #(
    parameter int MIN_GREEN   = 4,
    parameter int YELLOW_TIME = 2,
    parameter int RED_TIME    = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       S1,
    input  logic       S2,
    input  logic       S3,
    output logic [1:0] L1,
    output logic [1:0] L2,
    output logic [1:0] L3
);

    localparam logic [1:0] LT_RED = 2'b00;
    localparam logic [1:0] LT_GRN = 2'b01;
    localparam logic [1:0] LT_YEL = 2'b10;

    localparam logic [7:0] G_LAST = 8'(MIN_GREEN - 1);
    localparam logic [7:0] Y_LAST = 8'(YELLOW_TIME - 1);
    localparam logic [7:0] R_LAST = 8'(RED_TIME - 1);

    typedef enum logic [2:0] {
        RED_TO_NB,
        NB_GREEN,
        NB_YELLOW,
        RED_TO_EW,
        EW_GREEN,
        EW_YELLOW
    } state_e;

    state_e     currentstate;
    state_e     nextstate;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       eb_go_q;
    logic       eb_go_d;
    logic       wb_go_q;
    logic       wb_go_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            currentstate <= RED_TO_NB;
            cnt_q        <= 8'd0;
            eb_go_q      <= 1'b0;
            wb_go_q      <= 1'b0;
        end else begin
            currentstate <= nextstate;
            cnt_q        <= cnt_d;
            eb_go_q      <= eb_go_d;
            wb_go_q      <= wb_go_d;
        end
    end

    always_comb begin
        nextstate = currentstate;
        eb_go_d   = eb_go_q;
        wb_go_d   = wb_go_q;
        unique case (currentstate)
            RED_TO_NB: begin
                if (cnt_q == R_LAST) nextstate = NB_GREEN;
            end
            NB_GREEN: begin
                if (cnt_q >= G_LAST && (S2 || S3)) begin
                    nextstate = NB_YELLOW;
                    eb_go_d   = S2;
                    wb_go_d   = S3;
                end
            end
            NB_YELLOW: begin
                if (cnt_q == Y_LAST) nextstate = RED_TO_EW;
            end
            RED_TO_EW: begin
                if (cnt_q == R_LAST) nextstate = EW_GREEN;
            end
            EW_GREEN: begin
                if (cnt_q >= G_LAST && (S1 || !(S2 || S3)))
                    nextstate = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (cnt_q == Y_LAST) nextstate = RED_TO_NB;
            end
            default: nextstate = RED_TO_NB;
        endcase
    end

    // Dwell counter restarts on every state change and saturates.
    always_comb begin
        if (nextstate != currentstate) begin
            cnt_d = 8'd0;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        L1 = LT_RED;
        L2 = LT_RED;
        L3 = LT_RED;
        unique case (currentstate)
            NB_GREEN:  L1 = LT_GRN;
            NB_YELLOW: L1 = LT_YEL;
            EW_GREEN: begin
                if (eb_go_q) L2 = LT_GRN;
                if (wb_go_q) L3 = LT_GRN;
            end
            EW_YELLOW: begin
                if (eb_go_q) L2 = LT_YEL;
                if (wb_go_q) L3 = LT_YEL;
            end
            default: begin
                L1 = LT_RED;
                L2 = LT_RED;
                L3 = LT_RED;
            end
        endcase
    end

`ifdef FSM_SAFETY_ASSERT_EN
    a_no_conflict: assert property (@(posedge Clock)
        (L1 != LT_RED) |-> (L2 == LT_RED && L3 == LT_RED));

    a_no_illegal: assert property (@(posedge Clock)
        (L1 != 2'b11) && (L2 != 2'b11) && (L3 != 2'b11));

    a_legal_state: assert property (@(posedge Clock)
        currentstate inside {RED_TO_NB, NB_GREEN, NB_YELLOW,
                             RED_TO_EW, EW_GREEN, EW_YELLOW});

    // A timed state leaves exactly when its dwell count is reached.
    a_dwell_nby: assert property (@(posedge Clock) disable iff (Reset)
        (currentstate == NB_YELLOW) |->
        ((nextstate != currentstate) == (cnt_q == Y_LAST)));

    a_dwell_ewy: assert property (@(posedge Clock) disable iff (Reset)
        (currentstate == EW_YELLOW) |->
        ((nextstate != currentstate) == (cnt_q == Y_LAST)));

    a_dwell_rnb: assert property (@(posedge Clock) disable iff (Reset)
        (currentstate == RED_TO_NB) |->
        ((nextstate != currentstate) == (cnt_q == R_LAST)));

    a_dwell_rew: assert property (@(posedge Clock) disable iff (Reset)
        (currentstate == RED_TO_EW) |->
        ((nextstate != currentstate) == (cnt_q == R_LAST)));
`endif

endmodule

// File: tb/tb_fsm.sv
// Scoreboard bench for the 4th Ave / Harrison traffic-light controller.
// Expected light triples are queued per stimulus cycle and checked after the edge.
module tb_fsm;

    logic       Clock;
    logic       Reset;
    logic       S1;
    logic       S2;
    logic       S3;
    logic [1:0] L1;
    logic [1:0] L2;
    logic [1:0] L3;

    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] exp_q[$];

    // {L1,L2,L3}: RED=00, GREEN=01, YELLOW=10
    localparam logic [5:0] ALLR = 6'b00_00_00;
    localparam logic [5:0] NBG  = 6'b01_00_00;
    localparam logic [5:0] NBY  = 6'b10_00_00;
    localparam logic [5:0] EWG  = 6'b00_01_01;
    localparam logic [5:0] EWY  = 6'b00_10_10;
    localparam logic [5:0] EBG  = 6'b00_01_00;
    localparam logic [5:0] EBY  = 6'b00_10_00;
    localparam logic [5:0] WBG  = 6'b00_00_01;
    localparam logic [5:0] WBY  = 6'b00_00_10;

    fsm dut (
        .Clock (Clock),
        .Reset (Reset),
        .S1    (S1),
        .S2    (S2),
        .S3    (S3),
        .L1    (L1),
        .L2    (L2),
        .L3    (L3)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag,
                       input logic [5:0] got,
                       input logic [5:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t",
                     tag, got, want, $time);
        end
    endtask

    // Drive one sensor vector for one edge, then compare the outputs.
    task automatic step(input string tag,
                        input logic [2:0] s,
                        input logic [5:0] want);
        logic [5:0] e;
        logic       conflict;
        logic       has11;
        {S1, S2, S3} = s;
        exp_q.push_back(want);
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        chk(tag, {L1, L2, L3}, e);
        conflict = (L1 != 2'b00) && (L2 != 2'b00 || L3 != 2'b00);
        has11 = (L1 == 2'b11) || (L2 == 2'b11) || (L3 == 2'b11);
        chk("safety", {5'd0, conflict}, 6'd0);
        chk("no11", {5'd0, has11}, 6'd0);
    endtask

    task automatic rep(input string tag, input logic [2:0] s,
                       input logic [5:0] want, input int n);
        for (int i = 0; i < n; i++) step(tag, s, want);
    endtask

    initial begin
        Reset = 1'b1;
        {S1, S2, S3} = 3'b000;
        #1;

        rep("reset", 3'b000, ALLR, 2);
        Reset = 1'b0;
        rep("nb_rest", 3'b000, NBG, 7);

        step("s2_pulse", 3'b010, NBY);
        step("nby", 3'b000, NBY);
        step("r2ew", 3'b000, ALLR);
        rep("ebg", 3'b000, EBG, 4);
        rep("eby", 3'b000, EBY, 2);
        step("r2nb", 3'b000, ALLR);
        step("nbg", 3'b000, NBG);

        rep("nbg_min", 3'b011, NBG, 3);
        rep("nby", 3'b011, NBY, 2);
        step("r2ew", 3'b011, ALLR);
        step("ewg", 3'b011, EWG);
        rep("ewg_s1", 3'b111, EWG, 3);
        rep("ewy", 3'b111, EWY, 2);
        step("r2nb", 3'b111, ALLR);
        step("nbg", 3'b111, NBG);

        for (int k = 0; k < 2; k++) begin
            rep("alt_nbg", 3'b111, NBG, 3);
            rep("alt_nby", 3'b111, NBY, 2);
            step("alt_r2ew", 3'b111, ALLR);
            rep("alt_ewg", 3'b111, EWG, 4);
            rep("alt_ewy", 3'b111, EWY, 2);
            step("alt_r2nb", 3'b111, ALLR);
            step("alt_nbg", 3'b111, NBG);
        end

        rep("pre_nbg", 3'b111, NBG, 3);
        rep("pre_nby", 3'b111, NBY, 2);
        step("pre_r", 3'b111, ALLR);
        rep("pre_ewg", 3'b111, EWG, 4);
        step("pre_ewy", 3'b111, EWY);
        Reset = 1'b1;
        step("rst_ewy", 3'b000, ALLR);
        Reset = 1'b0;
        step("post_rst", 3'b000, NBG);
        rep("post_nbg", 3'b000, NBG, 3);
        step("s3_only", 3'b001, NBY);
        step("nby", 3'b000, NBY);
        step("r2ew", 3'b000, ALLR);
        rep("wbg", 3'b000, WBG, 4);
        rep("wby", 3'b000, WBY, 2);
        step("r2nb", 3'b000, ALLR);
        step("nbg", 3'b000, NBG);

        rep("sw100", 3'b100, NBG, 2);
        step("sw010", 3'b010, NBG);
        step("sw010", 3'b010, NBY);
        step("sw001", 3'b001, NBY);
        step("sw001", 3'b001, ALLR);
        rep("sw100", 3'b100, EBG, 2);
        rep("sw011", 3'b011, EBG, 2);
        rep("sw100", 3'b100, EBY, 2);
        step("sw101", 3'b101, ALLR);
        step("sw101", 3'b101, NBG);
        rep("sw110", 3'b110, NBG, 2);
        step("sw111", 3'b111, NBG);
        step("sw111", 3'b111, NBY);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL queue: got %0d left want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
